// File: rtl/musa_pkg.sv
// Branch-class encodings shared between the microprogrammed control unit and the PC stage.
package musa_pkg;

    localparam logic [2:0] BR_SEQ  = 3'b000;
    localparam logic [2:0] BR_JR   = 3'b001;
    localparam logic [2:0] BR_CALL = 3'b010;
    localparam logic [2:0] BR_HALT = 3'b011;
    localparam logic [2:0] BR_JPC  = 3'b100;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_SEQ,
        PC_JUMP,
        PC_REG,
        PC_REL,
        PC_RET
    } pc_src_e;

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address stack with a combinational top-of-stack read.
// Pushes while full and pops while empty are refused; the refusal is flagged by a one-cycle err pulse.
module ret_stack #(
    parameter int PC_W        = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [PC_W-1:0]                wdata,
    output logic [PC_W-1:0]                top,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           full,
    output logic                           empty,
    output logic                           err
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int DW = AW + 1;

    logic [PC_W-1:0] mem [STACK_DEPTH];

    assign full  = (depth == DW'(STACK_DEPTH));
    assign empty = (depth == '0);
    // When empty this index wraps to the last slot; callers never consume top in that case.
    assign top   = mem[AW'(depth - DW'(1))];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[AW'(depth)] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
            err   <= 1'b0;
        end else begin
            err <= (push && full) || (pop && empty);
            if (push && !full) begin
                depth <= depth + DW'(1);
            end else if (pop && !empty) begin
                depth <= depth - DW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and next-address selection for the microprogrammed core.
// Resolves sequential, jr, jpc, call, ret, brfl and halt commits on write_pc edges.
module pc_sequencer
    import musa_pkg::*;
#(
    parameter int              PC_W        = 16,
    parameter int              STACK_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          write_pc,
    input  logic [2:0]                    branch,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          add_pc,
    input  logic                          brfl_control,
    input  logic                          flag_match,
    input  logic [PC_W-1:0]               jump_addr,
    input  logic [PC_W-1:0]               reg_target,
    input  logic [PC_W-1:0]               offset,
    output logic [PC_W-1:0]               pc,
    output logic                          halted,
    output logic                          stk_err,
    output logic [$clog2(STACK_DEPTH):0]  stk_depth
);

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] stk_top;
    logic            stk_full;
    logic            stk_empty;
    logic            stk_refused;
    logic            push_req;
    logic            pop_req;
    logic            halt_set;
    logic            err_set;
    pc_src_e         pc_src;
    logic [PC_W-1:0] pc_next;

    assign pc_inc = pc + PC_W'(1);

    always_comb begin
        pc_src   = PC_HOLD;
        push_req = 1'b0;
        pop_req  = 1'b0;
        halt_set = 1'b0;
        err_set  = 1'b0;
        if (write_pc && !halted) begin
            if (branch == BR_HALT) begin
                halt_set = 1'b1;
            end else if (branch == BR_CALL && push) begin
                push_req = 1'b1;
                if (stk_full) begin
                    err_set  = 1'b1;
                    halt_set = 1'b1;
                end else begin
                    pc_src = PC_JUMP;
                end
            end else if (pop && add_pc) begin
                pop_req = 1'b1;
                if (stk_empty) begin
                    err_set  = 1'b1;
                    halt_set = 1'b1;
                end else begin
                    pc_src = PC_RET;
                end
            end else if (branch == BR_JR) begin
                pc_src = PC_REG;
            end else if (branch == BR_JPC) begin
                pc_src = PC_REL;
            end else if (brfl_control) begin
                pc_src = flag_match ? PC_JUMP : PC_SEQ;
            end else begin
                pc_src = PC_SEQ;
            end
        end
    end

    always_comb begin
        pc_next = pc;
        case (pc_src)
            PC_SEQ:  pc_next = pc_inc;
            PC_JUMP: pc_next = jump_addr;
            PC_REG:  pc_next = reg_target;
            PC_REL:  pc_next = pc_inc + offset;
            PC_RET:  pc_next = stk_top;
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            halted  <= 1'b0;
            stk_err <= 1'b0;
        end else begin
            pc      <= pc_next;
            halted  <= halted | halt_set;
            // The stack's own refusal pulse lands a cycle later and is redundant with err_set.
            stk_err <= stk_err | err_set | stk_refused;
        end
    end

    ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop_req),
        .wdata (pc_inc),
        .top   (stk_top),
        .depth (stk_depth),
        .full  (stk_full),
        .empty (stk_empty),
        .err   (stk_refused)
    );

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and return-address-stack stage driven by the microprogrammed control unit's branch-class outputs. The control unit drives `write_pc`, `branch[2:0]`, `push`, `pop`, `add_pc` and `brfl_control`. This block resolves the next instruction address, covering sequential, jr, jpc, call, ret, conditional brfl and halt. It holds the PC that feeds instruction fetch.

## Interface
- `PC_W`, 16: PC and address width (word-addressed).
- `STACK_DEPTH`, 8: return-address stack entries (power of two, ≥2).
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `write_pc`  in  1: one-cycle commit strobe; the PC updates only on an edge where this is 1.
- `branch`  in  3: 000 sequential, 001 jr, 010 call, 011 halt, 100 jpc; 101–111 are treated as sequential.
- `push`  in  1: call qualifier.
- `pop`  in  1: ret qualifier, used together with `add_pc`.
- `add_pc`  in  1: ret qualifier, used together with `pop`.
- `brfl_control`  in  1: conditional branch-on-flag instruction.
- `flag_match`  in  1: ALU flag test result for brfl; 1 means taken.
- `jump_addr`  in  PC_W: absolute target (call, taken brfl).
- `reg_target`  in  PC_W: register-file read data (jr).
- `offset`  in  PC_W: two's-complement displacement (jpc).
- `pc`  out  PC_W: current PC.
- `halted`  out  1: sticky halt.
- `stk_err`  out  1: sticky stack overflow/underflow.
- `stk_depth`  out  $clog2(STACK_DEPTH)+1: occupied entries.

## Operation
- Reset (edge with `rst`=1): `pc`=RESET_PC, `halted`=0, `stk_err`=0, `stk_depth`=0. Stack storage is not cleared. `rst` overrides `write_pc`.
- Edges with `write_pc`=0, or with `halted`=1, leave all state unchanged.
- On an edge with `write_pc`=1 and `halted`=0, the first matching rule applies:
  1. `branch`=011: `halted`←1; `pc` holds.
  2. `branch`=010 and `push`=1 (call):
     - Stack full: `stk_err`←1, `halted`←1, `pc` holds.
     - Otherwise: push `pc+1`, `pc`←`jump_addr`.
  3. `pop`=1 and `add_pc`=1 (ret):
     - Stack empty: `stk_err`←1, `halted`←1, `pc` holds.
     - Otherwise: `pc`←top entry, then pop.
  4. `branch`=001 (jr): `pc`←`reg_target`.
  5. `branch`=100 (jpc): `pc`←`pc+1+offset`.
  6. `brfl_control`=1: `pc`←`jump_addr` if `flag_match`=1, else `pc+1`.
  7. Otherwise: `pc`←`pc+1`.
- Lone `push` (without `branch`=010), or lone `pop`/`add_pc`, has no stack effect; the rule list continues.
- Arithmetic is modulo 2^PC_W. `pc+1` wraps from all-ones to 0. `offset` is full-width two's complement, with no sign-extension inside this block.
- Stack is LIFO:
  - push writes entry[`stk_depth`], then increments `stk_depth`.
  - pop reads entry[`stk_depth`-1], then decrements `stk_depth`.
  - `stk_depth` ranges 0..STACK_DEPTH; full means `stk_depth`==STACK_DEPTH.
- Once `halted`=1, only `rst` clears it.

## Timing
- All outputs are registered. The new `pc` is visible the cycle after the `write_pc` edge.
- The top-of-stack read is combinational from the stack array into the next-PC mux. This gives zero extra latency; ret completes in the same single edge.
- `jump_addr`, `reg_target`, `offset` and `flag_match` are sampled only on the `write_pc` edge, and must be stable in that cycle.
- `write_pc` on consecutive cycles is legal. Each edge is one independent commit.
- `halted`, `stk_err` and `stk_depth` update on the same edge as the triggering commit.

## Structure
- Shared package `musa_pkg` holds the branch code constants: BR_SEQ=3'b000, BR_JR=3'b001, BR_CALL=3'b010, BR_HALT=3'b011, BR_JPC=3'b100.
- The control unit imports the same constants.
- Sub-module `ret_stack` is parameterised by PC_W and STACK_DEPTH.
  - Inputs: push/pop strobes, write data.
  - Outputs: top, depth, full, empty.
  - It handles overflow/underflow refusal internally and reports it with a 1-cycle `err` pulse.
- The next-PC priority mux and the halt/err flags live in `pc_sequencer`.

## Test plan
- Reset, then 3 sequential commits (`branch`=000): `pc` steps 0→1→2→3. A 5-cycle idle gap with `write_pc`=0 leaves `pc`=3.
- At `pc`=5: call with `jump_addr`=0x0040, then 2 sequential commits, then ret (`pop`=`add_pc`=1): `pc` goes 0x40→0x41→0x42→6; `stk_depth` goes 1, then back to 0.
- At `pc`=0x10: jpc with `offset`=0xFFFC gives `pc`=0x000D. At `pc`=0xFFFF, a sequential commit gives 0x0000. jr with `reg_target`=0x1234 gives 0x1234.
- brfl with `jump_addr`=0x20:
  - `flag_match`=0 at `pc`=7 gives 8.
  - `flag_match`=1 gives 0x20.
- Call 8 times (depth 8), then a 9th call: `stk_err`=1, `halted`=1, `pc` unchanged. Further commits are ignored. `rst` clears everything and sets `pc`=0.
- ret from empty stack: `stk_err`=1, `halted`=1. Separately, `branch`=011 sets `halted` with `stk_err`=0. Asserting `rst` together with `write_pc` and a call gives the reset state with `stk_depth`=0.
